// File: rtl/vga_fb_pkg.sv
// Shared constants for the VGA framebuffer Wishbone reader: cycle-type codes,
// burst-type code and FSM state encoding.
package vga_fb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic [2:0] beat_cti(input logic last_beat);
    if (last_beat) begin
      return CTI_EOB;
    end else begin
      return CTI_INC;
    end
  endfunction

endpackage

// File: rtl/vga_fb_wb_reader_if.sv
// Wishbone B3 master port bundle between the framebuffer reader and the DDR2 arbiter.
interface vga_fb_wb_reader_if;
  logic [31:0] wbm_adr_o;
  logic [1:0]  wbm_bte_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;

  modport master (
    output wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
    output wbm_we_o, wbm_sel_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    input  wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_we_o, wbm_sel_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );
endinterface

// File: rtl/vga_fb_fifo.sv
// Single-clock first-word-fall-through pixel FIFO with flush; head word and
// valid are registered so the output holds its last value when the FIFO drains.
module vga_fb_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          valid,
  output logic [AW:0]   count
);
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_dout;
  logic          r_valid;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic [AW:0]   w_cnt_after_pop;
  logic [AW:0]   w_cnt_nxt;
  logic [AW-1:0] w_rd_nxt;

  always_comb begin
    w_push          = push & ~flush;
    w_pop           = pop & r_valid & ~flush;
    w_full          = (r_count == (AW+1)'(DEPTH));
    w_cnt_after_pop = r_count - (AW+1)'(w_pop);
    w_cnt_nxt       = w_cnt_after_pop + (AW+1)'(w_push);
    w_rd_nxt        = r_rd_ptr + AW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Next head comes straight from din when the entry being written becomes the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= 32'h0;
      r_valid  <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        if (w_cnt_after_pop == '0) r_dout <= din;
        else                       r_dout <= r_mem[w_rd_nxt];
      end
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
  assign count = r_count;

  vga_fb_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .full (w_full)
  );
endmodule

// File: rtl/vga_fb_fifo_chk.sv
// Simulation-only property checks for the pixel FIFO.
module vga_fb_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/vga_fb_wb_reader.sv
// Wishbone burst-read master streaming the VGA framebuffer into a pixel FIFO;
// a burst is only issued when the FIFO has room for a whole burst.
module vga_fb_wb_reader
  import vga_fb_pkg::*;
#(
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 64,
  parameter int FIFO_AW     = 6
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic                      enable_i,
  input  logic [31:0]               fb_base_i,
  input  logic                      frame_start_i,
  vga_fb_wb_reader_if.master        wbm,
  input  logic                      pix_rd_i,
  output logic [31:0]               pix_dat_o,
  output logic                      pix_valid_o,
  output logic                      underflow_o,
  output logic                      bus_err_o
);
  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int BLW = $clog2(BURST_LEN) + 1;

  logic [1:0]     r_state;
  logic [31:0]    r_adr;
  logic           r_cyc;
  logic           r_stb;
  logic [2:0]     r_cti;
  logic [WCW-1:0] r_word_cnt;
  logic [BLW-1:0] r_beat;
  logic [BLW-1:0] r_len;
  logic           r_pend;
  logic           r_underflow;
  logic           r_bus_err;

  logic           w_restart;
  logic           w_ack;
  logic           w_err;
  logic           w_flush;
  logic           w_push;
  logic [FIFO_AW:0] w_fifo_count;
  logic [FIFO_AW:0] w_free;
  logic [31:0]    w_remain;
  logic [BLW-1:0] w_first_len;
  logic           w_last_beat;
  logic           w_frame_done;

  // Handshake decode, free-space and burst-length computation.
  always_comb begin
    w_restart    = frame_start_i & enable_i;
    w_ack        = r_cyc & r_stb & wbm.wbm_ack_i;
    w_err        = r_cyc & wbm.wbm_err_i;
    w_flush      = w_restart | ((r_state == ST_IDLE) & ~enable_i);
    w_push       = w_ack & ~w_err & (r_state == ST_BURST);
    w_free       = (FIFO_AW+1)'(FIFO_DEPTH) - w_fifo_count;
    w_remain     = 32'(FRAME_WORDS) - 32'(r_word_cnt);
    if (w_remain < 32'(BURST_LEN)) w_first_len = w_remain[BLW-1:0];
    else                           w_first_len = BLW'(BURST_LEN);
    w_last_beat  = (r_beat + BLW'(1) == r_len);
    w_frame_done = (w_remain == 32'd1);
  end

  // Main FSM; a restart mid-burst parks in DRAIN for one cycle before refilling.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state    <= ST_IDLE;
      r_adr      <= 32'h0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_cti      <= CTI_CLASSIC;
      r_word_cnt <= '0;
      r_beat     <= '0;
      r_len      <= '0;
      r_pend     <= 1'b0;
    end else if (w_restart) begin
      r_adr      <= fb_base_i & 32'hFFFF_FFFC;
      r_word_cnt <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_cti      <= CTI_CLASSIC;
      if (r_state == ST_BURST) begin
        r_state <= ST_DRAIN;
        r_pend  <= 1'b1;
      end else begin
        r_state <= ST_FILL;
        r_pend  <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pend <= 1'b0;
        end
        ST_FILL: begin
          if (!enable_i) begin
            r_state <= ST_IDLE;
          end else if (w_free >= (FIFO_AW+1)'(BURST_LEN)) begin
            r_state <= ST_BURST;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_beat  <= '0;
            r_len   <= w_first_len;
            r_cti   <= beat_cti(w_first_len == BLW'(1));
          end
        end
        ST_BURST: begin
          if (w_err) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_cti   <= CTI_CLASSIC;
            r_pend  <= 1'b0;
            r_state <= ST_DRAIN;
          end else if (w_ack) begin
            r_adr      <= r_adr + 32'd4;
            r_word_cnt <= r_word_cnt + WCW'(1);
            r_beat     <= r_beat + BLW'(1);
            if (w_last_beat) begin
              r_cyc <= 1'b0;
              r_stb <= 1'b0;
              r_cti <= CTI_CLASSIC;
              if (w_frame_done || !enable_i) r_state <= ST_IDLE;
              else                           r_state <= ST_FILL;
            end else begin
              r_cti <= beat_cti(r_beat + BLW'(2) == r_len);
            end
          end
        end
        ST_DRAIN: begin
          r_pend <= 1'b0;
          if (r_pend && enable_i) r_state <= ST_FILL;
          else                    r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status flags, cleared by every frame start.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_underflow <= 1'b0;
      r_bus_err   <= 1'b0;
    end else if (frame_start_i) begin
      r_underflow <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_err && (r_state == ST_BURST)) r_bus_err <= 1'b1;
      if (pix_rd_i && !pix_valid_o)       r_underflow <= 1'b1;
    end
  end

  vga_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .flush (w_flush),
    .push  (w_push),
    .pop   (pix_rd_i),
    .din   (wbm.wbm_dat_i),
    .dout  (pix_dat_o),
    .valid (pix_valid_o),
    .count (w_fifo_count)
  );

  assign wbm.wbm_adr_o = r_adr;
  assign wbm.wbm_bte_o = BTE_LINEAR;
  assign wbm.wbm_cti_o = r_cti;
  assign wbm.wbm_cyc_o = r_cyc;
  assign wbm.wbm_stb_o = r_stb;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = 4'hF;
  assign wbm.wbm_dat_o = 32'h0;
  assign underflow_o   = r_underflow;
  assign bus_err_o     = r_bus_err;
endmodule

// File: tb/tb_vga_fb_wb_reader.sv
// Scoreboard bench for vga_fb_wb_reader: a Wishbone slave model checks every
// beat, a pixel monitor checks every popped word against an expected queue.
module tb_vga_fb_wb_reader;
  localparam int FW = 68;

  logic        clk;
  logic        wb_rst;
  logic        enable;
  logic [31:0] fb_base;
  logic        frame_start;
  logic        pix_rd;
  logic [31:0] pix_dat;
  logic        pix_valid;
  logic        underflow;
  logic        bus_err;

  vga_fb_wb_reader_if wbif ();

  vga_fb_wb_reader #(.FRAME_WORDS(FW), .BURST_LEN(8), .FIFO_DEPTH(64), .FIFO_AW(6)) dut (
    .wb_clk        (clk),
    .wb_rst        (wb_rst),
    .enable_i      (enable),
    .fb_base_i     (fb_base),
    .frame_start_i (frame_start),
    .wbm           (wbif),
    .pix_rd_i      (pix_rd),
    .pix_dat_o     (pix_dat),
    .pix_valid_o   (pix_valid),
    .underflow_o   (underflow),
    .bus_err_o     (bus_err)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          exp_idx = 0;
  logic [31:0] exp_base = 32'h0;
  logic [31:0] nxt_base = 32'h0;
  bit          err_arm = 1'b0;
  bit          err_seen = 1'b0;
  int          cyc_hi_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] wdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Wishbone slave model: acks every strobed cycle, checks address/cti per beat.
  initial begin
    wbif.wbm_ack_i = 1'b0;
    wbif.wbm_err_i = 1'b0;
    wbif.wbm_rty_i = 1'b0;
    wbif.wbm_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      wbif.wbm_ack_i = 1'b0;
      wbif.wbm_err_i = 1'b0;
      if (wbif.wbm_cyc_o) cyc_hi_cnt++;
      if (!wb_rst && wbif.wbm_cyc_o && wbif.wbm_stb_o) begin
        if (err_arm && (exp_idx % 8 == 3)) begin
          wbif.wbm_err_i = 1'b1;
          err_arm  = 1'b0;
          err_seen = 1'b1;
        end else begin
          check("beat_adr", wbif.wbm_adr_o, exp_base + 32'(exp_idx * 4));
          check("beat_cti", {29'd0, wbif.wbm_cti_o},
                ((exp_idx % 8 == 7) || (exp_idx == FW - 1)) ? 32'd7 : 32'd2);
          check("beat_ctl", {25'd0, wbif.wbm_we_o, wbif.wbm_sel_o, wbif.wbm_bte_o}, 32'h3C);
          wbif.wbm_dat_i = wdata(wbif.wbm_adr_o);
          wbif.wbm_ack_i = 1'b1;
          exp_idx++;
        end
      end
      if (frame_start && enable) begin
        exp_idx  = 0;
        exp_base = nxt_base;
      end
    end
  end

  // Pixel monitor: every accepted pop is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_rd && pix_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL pix_unexpected: got %h expected no word", pix_dat);
        end else begin
          check("pix_dat", pix_dat, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Call at posedge+1; pulses frame_start for one cycle and loads the scoreboard.
  task automatic start_frame(input logic [31:0] base_in, input logic [31:0] base_exp);
    fb_base     = base_in;
    frame_start = 1'b1;
    nxt_base    = base_exp;
    exp_q.delete();
    for (int i = 0; i < FW; i++) exp_q.push_back(wdata(base_exp + 32'(4 * i)));
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pop_n(input int n);
    @(posedge clk); #1;
    pix_rd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    pix_rd = 1'b0;
  endtask

  task automatic drain_all(input string nm);
    @(posedge clk); #1;
    pix_rd = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    pix_rd = 1'b0;
    check(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    wb_rst = 1'b1; enable = 1'b0; fb_base = 32'h0; frame_start = 1'b0; pix_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_cyc", wbif.wbm_cyc_o, 1'b0);
    check1("rst_stb", wbif.wbm_stb_o, 1'b0);
    check("rst_adr", wbif.wbm_adr_o, 32'h0);
    check("rst_ctl", {23'd0, wbif.wbm_cti_o, wbif.wbm_bte_o, wbif.wbm_we_o, wbif.wbm_sel_o}, 32'h0F);
    check("rst_pix_dat", pix_dat, 32'h0);
    check("rst_flags", {29'd0, pix_valid, underflow, bus_err}, 32'h0);
    wb_rst = 1'b0;
    enable = 1'b1;

    // Frame at 0x100 (low address bits ignored); fills the FIFO to 64 and stops.
    @(posedge clk); #1;
    start_frame(32'h103, 32'h100);
    @(negedge clk);
    check1("restart_cyc_low", wbif.wbm_cyc_o, 1'b0);
    @(negedge clk);
    check1("first_stb", wbif.wbm_stb_o, 1'b1);
    check("first_adr", wbif.wbm_adr_o, 32'h100);
    repeat (150) @(posedge clk);
    #1;
    check("fill_words", exp_idx, 32'd64);
    check1("fill_cyc_low", wbif.wbm_cyc_o, 1'b0);
    check1("fill_valid", pix_valid, 1'b1);
    cyc_hi_cnt = 0;
    pop_n(4);
    repeat (10) @(posedge clk);
    #1;
    check("no_burst_at_60", cyc_hi_cnt, 32'd0);
    pop_n(4);
    @(negedge clk);
    check1("burst_wait_57", wbif.wbm_cyc_o, 1'b0);
    @(negedge clk);
    check1("burst_at_56", wbif.wbm_cyc_o, 1'b1);
    check("burst_at_56_adr", wbif.wbm_adr_o, 32'h200);
    drain_all("frame_a_words");
    cyc_hi_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("frame_a_idle", cyc_hi_cnt, 32'd0);
    check("frame_a_beats", exp_idx, 32'd68);

    // Bus error on beat 3.
    err_arm = 1'b1;
    @(posedge clk); #1;
    start_frame(32'h4000, 32'h4000);
    for (int i = 0; i < 100 && !err_seen; i++) @(posedge clk);
    check1("err_issued", err_seen, 1'b1);
    @(negedge clk);
    check1("err_cyc_drop", wbif.wbm_cyc_o, 1'b0);
    check1("err_flag", bus_err, 1'b1);
    cyc_hi_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    check("err_no_fetch", cyc_hi_cnt, 32'd0);
    check("err_beats", exp_idx, 32'd3);
    pop_n(3);
    @(negedge clk);
    check1("err_fifo_empty", pix_valid, 1'b0);

    // New frame clears the flag; restart during beat 5 to base 0x8000.
    @(posedge clk); #1;
    start_frame(32'h6000, 32'h6000);
    @(negedge clk);
    check1("err_flag_clr", bus_err, 1'b0);
    for (int i = 0; i < 50 && exp_idx != 5; i++) begin
      @(posedge clk); #1;
    end
    check("restart_at_beat5", exp_idx, 32'd5);
    start_frame(32'h8000, 32'h8000);
    @(negedge clk);
    check1("restart_cyc_drop", wbif.wbm_cyc_o, 1'b0);
    check1("restart_flushed", pix_valid, 1'b0);
    for (int i = 0; i < 10 && !wbif.wbm_cyc_o; i++) @(negedge clk);
    check1("restart_cyc", wbif.wbm_cyc_o, 1'b1);
    check("restart_adr", wbif.wbm_adr_o, 32'h8000);
    drain_all("frame_c_words");
    @(negedge clk);
    check("hold_last", pix_dat, wdata(32'h810C));

    // Disabled: frame_start only clears flags; empty read sets underflow.
    @(posedge clk); #1;
    enable = 1'b0;
    fb_base = 32'h55;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check1("uf_cleared", underflow, 1'b0);
    cyc_hi_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    check("disabled_no_fetch", cyc_hi_cnt, 32'd0);
    pix_rd = 1'b1;
    @(posedge clk); #1;
    pix_rd = 1'b0;
    @(negedge clk);
    check1("uf_set", underflow, 1'b1);
    check1("uf_valid", pix_valid, 1'b0);
    check("uf_dat_held", pix_dat, wdata(32'h810C));

    // Reset mid-burst drops cyc/stb without a clock edge.
    @(posedge clk); #1;
    enable = 1'b1;
    start_frame(32'h100, 32'h100);
    for (int i = 0; i < 10 && !wbif.wbm_cyc_o; i++) @(negedge clk);
    check1("pre_rst_cyc", wbif.wbm_cyc_o, 1'b1);
    @(posedge clk); #2;
    wb_rst = 1'b1;
    #1;
    check1("async_rst_cyc", wbif.wbm_cyc_o, 1'b0);
    check1("async_rst_stb", wbif.wbm_stb_o, 1'b0);
    check1("async_rst_valid", pix_valid, 1'b0);
    @(posedge clk); #1;
    wb_rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
